// File: rtl/hc595_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hc595_pkg
//  Description : Shared types and defaults for the 74HC595 serial transmitter.
//                - hc595_state_e : transmitter FSM states
//                - C_CLK_DIV_DEFAULT / C_N_BITS_DEFAULT : default parameters
//                - cnt_width()   : counter width able to hold n-1 (min 1 bit)
//  Revision    : 1.0 - initial release
// ============================================================================
package hc595_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } hc595_state_e;

  localparam int unsigned C_CLK_DIV_DEFAULT = 2;
  localparam int unsigned C_N_BITS_DEFAULT  = 16;

  // Width needed to count 0..n-1 without wrapping; never below 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hc595_shift_tx_tick.sv
`default_nettype none
// ============================================================================
//  Module      : hc595_tick
//  Description : Half-period tick generator. o_tick is high on the last clk
//                cycle of every CLK_DIV-cycle window; i_clr restarts the
//                window from zero on the next edge.
//  Ports       : clk    - system clock
//                rst_n  - asynchronous active-low reset
//                i_clr  - synchronous clear of the window counter
//                o_tick - end-of-window strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module hc595_tick
  import hc595_pkg::*;
#(
  parameter int unsigned CLK_DIV = C_CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned      C_W    = cnt_width(CLK_DIV);
  localparam logic [C_W-1:0]   C_LAST = C_W'(CLK_DIV - 1);

  logic [C_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + C_W'(1);
    end
  end

  assign o_tick = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/hc595_shift_tx.sv
`default_nettype none
// ============================================================================
//  Module      : hc595_shift_tx
//  Description : Serialises an N_BITS frame (MSB first) into one or more
//                cascaded 74HC595 shift registers, then pulses the storage
//                latch. One frame in flight at a time; no queuing.
//  Ports       : clk      - system clock (rising edge)
//                rst_n    - asynchronous active-low reset
//                in_data  - frame to send, bit N_BITS-1 first
//                in_valid - frame request
//                in_ready - idle and able to accept a frame
//                ds       - serial data to DS
//                sh_cp    - shift clock (DS sampled on its rising edge)
//                st_cp    - storage latch (outputs update on its rising edge)
//  Revision    : 1.0 - initial release
// ============================================================================
module hc595_shift_tx
  import hc595_pkg::*;
#(
  parameter int unsigned CLK_DIV = C_CLK_DIV_DEFAULT,
  parameter int unsigned N_BITS  = C_N_BITS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_BITS-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ds,
  output logic              sh_cp,
  output logic              st_cp
);

  localparam int unsigned      C_BW       = cnt_width(N_BITS);
  localparam logic [C_BW-1:0]  C_LAST_BIT = C_BW'(N_BITS - 1);

  hc595_state_e      r_state,    w_state_next;
  logic [C_BW-1:0]   r_bit_cnt,  w_bit_cnt_next;
  logic [N_BITS-1:0] r_shreg,    w_shreg_next;
  logic              r_ds,       w_ds_next;
  logic              r_sh_cp,    w_sh_cp_next;
  logic              r_st_cp,    w_st_cp_next;
  logic              r_in_ready, w_in_ready_next;

  logic w_tick;
  logic w_tick_clr;

  // Restart the half-period window on every state entry so each phase
  // starts with a full CLK_DIV cycles.
  assign w_tick_clr = (w_state_next != r_state);

  hc595_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_tick_clr),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
      r_ds       <= 1'b0;
      r_sh_cp    <= 1'b0;
      r_st_cp    <= 1'b0;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_shreg    <= w_shreg_next;
      r_ds       <= w_ds_next;
      r_sh_cp    <= w_sh_cp_next;
      r_st_cp    <= w_st_cp_next;
      r_in_ready <= w_in_ready_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_bit_cnt_next  = r_bit_cnt;
    w_shreg_next    = r_shreg;
    w_ds_next       = r_ds;
    w_sh_cp_next    = r_sh_cp;
    w_st_cp_next    = r_st_cp;
    w_in_ready_next = r_in_ready;

    case (r_state)
      IDLE: begin
        w_ds_next       = 1'b0;
        w_sh_cp_next    = 1'b0;
        w_st_cp_next    = 1'b0;
        // Comes up the first edge after reset release.
        w_in_ready_next = 1'b1;
        if (in_valid && r_in_ready) begin
          w_state_next    = SHIFT;
          w_shreg_next    = in_data;
          // MSB presented immediately: it gets a full low phase of setup.
          w_ds_next       = in_data[N_BITS-1];
          w_in_ready_next = 1'b0;
        end
      end

      SHIFT: begin
        if (w_tick) begin
          if (!r_sh_cp) begin
            w_sh_cp_next = 1'b1;
          end else begin
            // Falling edge of sh_cp: start of the next bit's low phase,
            // the only point where ds may change.
            w_sh_cp_next = 1'b0;
            if (r_bit_cnt == C_LAST_BIT) begin
              w_state_next = LATCH;
              w_st_cp_next = 1'b1;
              w_ds_next    = 1'b0;
            end else begin
              w_bit_cnt_next = r_bit_cnt + C_BW'(1);
              w_shreg_next   = r_shreg << 1;
              w_ds_next      = w_shreg_next[N_BITS-1];
            end
          end
        end
      end

      LATCH: begin
        w_sh_cp_next = 1'b0;
        if (w_tick) begin
          if (r_st_cp) begin
            w_st_cp_next = 1'b0;
          end else begin
            w_state_next    = IDLE;
            w_in_ready_next = 1'b1;
          end
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase

    if (w_state_next != r_state) begin
      w_bit_cnt_next = '0;
    end
  end

  assign in_ready = r_in_ready;
  assign ds       = r_ds;
  assign sh_cp    = r_sh_cp;
  assign st_cp    = r_st_cp;

endmodule
`default_nettype wire

// File: tb/tb_hc595_shift_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hc595_shift_tx
//  Description : Scoreboard bench for hc595_shift_tx. Channel 0 uses
//                CLK_DIV=2, channel 1 uses CLK_DIV=1. Each channel drives a
//                model of two chained 74HC595s; on every st_cp rise the
//                latched {chip B, chip A} outputs are compared with the next
//                expected frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hc595_shift_tx;

  localparam int NB = 16;

  function automatic int cd(input int c);
    return (c == 0) ? 2 : 1;
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] in_data  [2];
  logic        in_valid [2];
  logic        in_ready [2];
  logic        ds       [2];
  logic        sh_cp    [2];
  logic        st_cp    [2];

  generate
    for (genvar g = 0; g < 2; g++) begin : g_dut
      hc595_shift_tx #(
        .CLK_DIV (g == 0 ? 2 : 1),
        .N_BITS  (NB)
      ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data[g]),
        .in_valid (in_valid[g]),
        .in_ready (in_ready[g]),
        .ds       (ds[g]),
        .sh_cp    (sh_cp[g]),
        .st_cp    (st_cp[g])
      );
    end
  endgenerate

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                  name, act, act, exp, exp, $time);
  endtask

  typedef struct {
    int          ch;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_tmp;
  int   acc_log[$];

  int cyc = 0;
  always @(posedge clk) cyc++;

  int         acc     [2];
  int         edges   [2];
  int         st_cnt  [2] = '{0, 0};
  logic       busy    [2];
  logic       prev_sh [2];
  logic       prev_st [2];
  logic [7:0] sr_a    [2];
  logic [7:0] sr_b    [2];

  // Monitor: bench model of two cascaded 74HC595 per channel plus timing.
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (!rst_n) begin
        busy[c]    = 1'b0;
        prev_sh[c] = 1'b0;
        prev_st[c] = 1'b0;
      end else begin
        if (sh_cp[c] && !prev_sh[c]) begin
          sr_b[c] = {sr_b[c][6:0], sr_a[c][7]};
          sr_a[c] = {sr_a[c][6:0], ds[c]};
          edges[c]++;
          if (edges[c] == 1) check("first_sh_rise_latency", cyc - acc[c], cd(c));
        end
        if (st_cp[c] && !prev_st[c]) begin
          st_cnt[c]++;
          check("sh_edges_per_frame", edges[c], NB);
          check("latch_has_expected_frame", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e_tmp = exp_q.pop_front();
            check("latch_channel", c, e_tmp.ch);
            check("latched_q", int'({sr_b[c], sr_a[c]}), int'(e_tmp.data));
          end
        end
        if (busy[c] && in_ready[c]) begin
          check("ready_low_cycles", cyc - acc[c], (2 * NB + 2) * cd(c));
          busy[c] = 1'b0;
        end
        if (in_valid[c] && in_ready[c]) begin
          acc[c]   = cyc + 1;
          busy[c]  = 1'b1;
          edges[c] = 0;
          acc_log.push_back(cyc + 1);
        end
        prev_sh[c] = sh_cp[c];
        prev_st[c] = st_cp[c];
      end
    end
  end

  task automatic wait_ready(input int c);
    int n = 0;
    while (!in_ready[c] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("ready_within_budget", int'(in_ready[c]), 1);
  endtask

  task automatic send(input int c, input logic [15:0] data, input bit push);
    wait_ready(c);
    @(posedge clk);
    #1;
    in_data[c]  = data;
    in_valid[c] = 1'b1;
    if (push) exp_q.push_back('{c, data});
    @(posedge clk);
    #1;
    in_valid[c] = 1'b0;
  endtask

  task automatic settle(input int c);
    wait_ready(c);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] hex8 [4] = '{16'hC0_01, 16'hF9_02, 16'hA4_04, 16'hB0_08};

  initial begin
    int s0;
    int n;
    for (int c = 0; c < 2; c++) begin
      in_data[c]  = 16'h0000;
      in_valid[c] = 1'b0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++)
      check("reset_outputs", int'({ds[c], sh_cp[c], st_cp[c], in_ready[c]}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++)
      check("ready_after_reset_release", int'(in_ready[c]), 1);

    // Basic frame, CLK_DIV=2
    s0 = st_cnt[0];
    send(0, 16'hC001, 1'b1);
    settle(0);
    check("c001_latch_pulses", st_cnt[0] - s0, 1);

    // CLK_DIV=1, all ones
    s0 = st_cnt[1];
    send(1, 16'hFFFF, 1'b1);
    settle(1);
    check("ffff_latch_pulses", st_cnt[1] - s0, 1);

    // Request during a frame is ignored
    s0 = st_cnt[0];
    acc_log.delete();
    send(0, 16'hA5A5, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    in_data[0]  = 16'h0000;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    settle(0);
    check("a5a5_latch_pulses", st_cnt[0] - s0, 1);
    check("a5a5_accepts", acc_log.size(), 1);

    // Back-to-back with in_valid held high
    s0 = st_cnt[0];
    acc_log.delete();
    wait_ready(0);
    @(posedge clk);
    #1;
    in_data[0]  = 16'h1234;
    in_valid[0] = 1'b1;
    exp_q.push_back('{0, 16'h1234});
    exp_q.push_back('{0, 16'h5678});
    @(posedge clk);
    #1;
    in_data[0] = 16'h5678;
    wait_ready(0);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    settle(0);
    check("b2b_latch_pulses", st_cnt[0] - s0, 2);
    check("b2b_accepts", acc_log.size(), 2);
    if (acc_log.size() == 2)
      check("b2b_accept_spacing", acc_log[1] - acc_log[0], (2 * NB + 2) * 2 + 1);

    // Reset mid-frame after the 7th sh_cp rise (ds=1, sh_cp=1 at that moment)
    s0 = st_cnt[0];
    send(0, 16'h3E5A, 1'b0);
    n = 0;
    while (edges[0] < 7 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("reached_7th_edge", edges[0], 7);
    #1;
    rst_n = 1'b0;
    #1;
    check("midframe_reset_outputs", int'({ds[0], sh_cp[0], st_cp[0], in_ready[0]}), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_no_latch", st_cnt[0] - s0, 0);
    send(0, 16'h8421, 1'b1);
    settle(0);
    check("post_reset_latch_pulses", st_cnt[0] - s0, 1);

    // Hex8-style {seg, sel} frames through the chained model
    for (int i = 0; i < 4; i++) send(0, hex8[i], 1'b1);
    settle(0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hc595_shift_tx.md
HC595_SHIFT_TX -- requirements
Module: hc595_shift_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning clk cycles per SCLK half-period; legal range 1..255.
REQ-002 SHALL have parameter N_BITS, default 16, meaning bits per frame ({seg[7:0], sel[7:0]} for two cascaded 74HC595).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_data  input  N_BITS  frame to shift out; bit N_BITS-1 is sent first.
REQ-006 SHALL have port in_valid  input  1  frame request.
REQ-007 SHALL have port in_ready  output  1  high when idle and able to accept a frame.
REQ-008 SHALL have port ds  output  1  serial data to the 74HC595 DS pin.
REQ-009 SHALL have port sh_cp  output  1  shift clock; the 74HC595 samples ds on its rising edge.
REQ-010 SHALL have port st_cp  output  1  storage-register latch; its rising edge updates the parallel outputs.

Function
REQ-011 SHALL accept a frame on the rising edge where in_valid && in_ready, capture in_data into an internal shift register, and deassert in_ready from the next cycle.
REQ-012 SHALL ignore in_valid while in_ready is low; no queuing, and in_data changes do not affect a frame in flight.
REQ-013 SHALL use FSM states IDLE, SHIFT, LATCH: IDLE->SHIFT on accept; SHIFT->LATCH after the last sh_cp high phase; LATCH->IDLE after the st_cp low phase.
REQ-014 SHALL, in SHIFT, emit each bit as sh_cp low for CLK_DIV cycles with ds stable, then sh_cp high for CLK_DIV cycles with ds held.
REQ-015 SHALL change ds only while sh_cp is low, at the start of each bit's low phase; setup and hold are each CLK_DIV cycles.
REQ-016 SHALL produce exactly N_BITS sh_cp rising edges per frame; the rising edge for bit k (k=0 is the MSB) occurs CLK_DIV*(2k+1) cycles after the accept edge.
REQ-017 SHALL, in LATCH, drive sh_cp low and st_cp high for CLK_DIV cycles, then st_cp low for CLK_DIV cycles.
REQ-018 SHALL keep in_ready low for exactly (2*N_BITS+2)*CLK_DIV cycles after the accept edge; for the defaults this is 68 cycles.
REQ-019 SHALL allow back-to-back frames: when in_valid is held high, the next accept occurs on the first cycle in_ready is high.
REQ-020 SHALL drive ds=0, sh_cp=0 and st_cp=0 in IDLE.
REQ-021 SHALL size the divider and bit counters to hold CLK_DIV-1 and N_BITS-1 without wrap; both counters clear to 0 on every state entry.

Reset
REQ-022 SHALL, while rst_n is low, force state=IDLE, counters=0, shift register=0, ds=0, sh_cp=0, st_cp=0 and in_ready=0.
REQ-023 SHALL raise in_ready on the first clk edge after rst_n deasserts.
REQ-024 SHALL, on reset asserted mid-frame, abort the frame immediately, with no st_cp pulse issued for the partial frame.

Structure
REQ-025 SHALL place the state enum (IDLE, SHIFT, LATCH) and default constants (CLK_DIV=2, N_BITS=16) in shared package hc595_pkg.
REQ-026 SHALL contain one sub-module, hc595_tick, a CLK_DIV half-period tick generator with synchronous clear; all other logic is inline.

Verification
REQ-027 SHALL cover: reset release, in_valid=1 with in_data=16'hC0_01 -> 16 sh_cp rising edges; ds sampled at those edges reads 1100_0000_0000_0001; one st_cp pulse; in_ready returns high 68 cycles after accept.
REQ-028 SHALL cover: CLK_DIV=1, in_data=16'hFFFF -> sh_cp period of 2 cycles, ds constantly 1, in_ready low for 34 cycles.
REQ-029 SHALL cover: new in_valid with in_data=16'h0000 pulsed during a frame of 16'hA5A5 -> serialized bits remain A5A5, the second request is not captured, and exactly one st_cp pulse occurs.
REQ-030 SHALL cover: in_valid held high across two frames, 16'h1234 then 16'h5678 -> exactly 1 idle cycle between frames and two st_cp pulses, in order.
REQ-031 SHALL cover: rst_n asserted after the 7th sh_cp edge -> all outputs 0 asynchronously, no st_cp pulse, and a clean full frame after reset release.
REQ-032 SHALL cover: a bench 74HC595 model chained twice, driven by hex8-style frames {seg, sel} -> model Q outputs equal the frame after each st_cp pulse.
